// File: rtl/system_top.sv
// ---------------------------------------------------------------------------
// system_top
//
// Bring-up / loopback image for the quadcopter controller host serial link.
// A UART 8N1 receiver feeds a one-byte echo buffer, and a UART 8N1
// transmitter drains that buffer back to the host. A status LED toggles once
// for every correctly framed byte received. Everything runs on one clock.
//
// Parameters
//   clk_freq        system clock frequency in Hz
//   uart_baud_rate  serial bit rate; bit period DIV = clk_freq / uart_baud_rate
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   led       out  status LED, toggles on each valid received byte
//   uart_rxd  in   serial input from host (asynchronous, idle high)
//   uart_txd  out  serial output to host (idle high)
// ---------------------------------------------------------------------------
module system_top #(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 38400
) (
    input  logic clk,
    input  logic rst,
    output logic led,
    input  logic uart_rxd,
    output logic uart_txd
);

    localparam int DIV  = clk_freq / uart_baud_rate;
    localparam int HALF = DIV / 2;
    // Counters only ever hold 0..DIV-1.
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO      = '0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // -----------------------------------------------------------------------
    // RX synchronizer and falling-edge detect.
    // All three flops reset to 1 (idle line) so leaving reset never looks
    // like a start bit.
    // -----------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // -----------------------------------------------------------------------
    // RX state machine
    // -----------------------------------------------------------------------
    rx_state_t       r_rx_state;
    rx_state_t       w_rx_state_next;
    logic [CW-1:0]   r_rx_cnt;
    logic [CW-1:0]   w_rx_cnt_next;
    logic [2:0]      r_rx_bit;
    logic [2:0]      w_rx_bit_next;
    logic [7:0]      r_rx_shift;
    logic [7:0]      w_rx_shift_next;
    logic            w_rx_valid;
    logic [7:0]      w_rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_valid      = 1'b0;

        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = CNT_ZERO;
                if (w_rx_fall) begin
                    w_rx_state_next = RX_START;
                end
            end

            RX_START: begin
                // Re-check the line half a bit in; a high here means the
                // falling edge was noise, not a start bit.
                if (r_rx_cnt == CNT_HALF_LAST) begin
                    w_rx_cnt_next = CNT_ZERO;
                    w_rx_bit_next = 3'd0;
                    if (!r_rx_sync) begin
                        w_rx_state_next = RX_DATA;
                    end else begin
                        w_rx_state_next = RX_IDLE;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_ONE;
                end
            end

            RX_DATA: begin
                if (r_rx_cnt == CNT_DIV_LAST) begin
                    w_rx_cnt_next   = CNT_ZERO;
                    // LSB arrives first, so shift in from the top.
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_next = RX_STOP;
                    end else begin
                        w_rx_bit_next = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_ONE;
                end
            end

            RX_STOP: begin
                if (r_rx_cnt == CNT_DIV_LAST) begin
                    w_rx_cnt_next   = CNT_ZERO;
                    w_rx_state_next = RX_IDLE;
                    // A low stop bit is a framing error: drop silently.
                    w_rx_valid      = r_rx_sync;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + CNT_ONE;
                end
            end

            default: begin
                w_rx_state_next = RX_IDLE;
                w_rx_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    assign w_rx_data = r_rx_shift;

    // -----------------------------------------------------------------------
    // Echo buffer: one byte plus full flag. The rx write is placed after the
    // TX load clear so that a byte arriving in the same cycle as a load
    // re-arms the flag instead of being lost. A byte arriving while already
    // full simply overwrites (last-wins).
    // -----------------------------------------------------------------------
    logic [7:0] r_buf_data;
    logic       r_buf_full;
    logic       w_tx_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_data <= 8'd0;
            r_buf_full <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_buf_full <= 1'b0;
            end
            if (w_rx_valid) begin
                r_buf_data <= w_rx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // TX state machine
    // -----------------------------------------------------------------------
    tx_state_t       r_tx_state;
    tx_state_t       w_tx_state_next;
    logic [CW-1:0]   r_tx_cnt;
    logic [CW-1:0]   w_tx_cnt_next;
    logic [2:0]      r_tx_bit;
    logic [2:0]      w_tx_bit_next;
    logic [7:0]      r_tx_shift;
    logic [7:0]      w_tx_shift_next;
    logic            w_txd_level;
    logic            r_txd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_load       = 1'b0;
        w_txd_level     = 1'b1;

        case (r_tx_state)
            TX_IDLE: begin
                w_txd_level   = 1'b1;
                w_tx_cnt_next = CNT_ZERO;
                if (r_buf_full) begin
                    w_tx_load       = 1'b1;
                    w_tx_shift_next = r_buf_data;
                    w_tx_state_next = TX_START;
                end
            end

            TX_START: begin
                w_txd_level = 1'b0;
                if (r_tx_cnt == CNT_DIV_LAST) begin
                    w_tx_cnt_next   = CNT_ZERO;
                    w_tx_bit_next   = 3'd0;
                    w_tx_state_next = TX_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_ONE;
                end
            end

            TX_DATA: begin
                w_txd_level = r_tx_shift[0];
                if (r_tx_cnt == CNT_DIV_LAST) begin
                    w_tx_cnt_next   = CNT_ZERO;
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_next = TX_STOP;
                    end else begin
                        w_tx_bit_next = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_ONE;
                end
            end

            TX_STOP: begin
                w_txd_level = 1'b1;
                if (r_tx_cnt == CNT_DIV_LAST) begin
                    w_tx_cnt_next   = CNT_ZERO;
                    w_tx_state_next = TX_IDLE;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + CNT_ONE;
                end
            end

            default: begin
                w_tx_state_next = TX_IDLE;
                w_tx_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Registered line driver: glitch-free pin, and the reset edge forces the
    // line high immediately even mid-frame. It trails the state by one cycle,
    // which keeps every bit exactly DIV cycles long.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd <= 1'b1;
        end else begin
            r_txd <= w_txd_level;
        end
    end

    assign uart_txd = r_txd;

    // -----------------------------------------------------------------------
    // Status LED
    // -----------------------------------------------------------------------
    logic r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= 1'b0;
        end else if (w_rx_valid) begin
            r_led <= ~r_led;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_system_top.sv
// ---------------------------------------------------------------------------
// tb_system_top
//
// Directed bench for system_top with DIV = 10 (1 MHz clock, 100 kbaud).
// Drives 8N1 frames into uart_rxd, captures the echoed frames on uart_txd
// cycle by cycle and compares them against hand-built expected waveforms.
// ---------------------------------------------------------------------------
module tb_system_top;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = 10;
    localparam int TIMEOUT  = 400;

    logic clk = 1'b0;
    logic rst;
    logic led;
    logic uart_rxd;
    logic uart_txd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic exp_led;
    int   last_start_cyc;
    int   idle0, idle1, idle2;
    int   fall0, fall1, fall2;
    int   bad;
    bit   found;

    system_top #(
        .clk_freq       (CLK_FREQ),
        .uart_baud_rate (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led      (led),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Caller must be at posedge+#1; consecutive calls produce zero-gap frames.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            if (i == 0) last_start_cyc = cyc;
            repeat (DIV) @(posedge clk);
            #1;
        end
        $display("tb: sent byte 0x%02h stop=%0d", b, stop_bit);
    endtask

    // Waits for an echo start bit, then captures 10*DIV samples and checks
    // each bit cell holds the expected level for all DIV cycles.
    task automatic recv_echo(input logic [7:0] b, input string tag,
                             output int idle, output int fall_cyc);
        logic [99:0] s;
        logic [9:0]  frame;
        bit          seen;
        frame    = {1'b1, b, 1'b0};
        idle     = 0;
        fall_cyc = -1;
        seen     = 1'b0;
        s        = '0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) seen = 1'b1;
            else idle++;
        end
        check($sformatf("%s_start_seen", tag), {31'd0, seen}, 32'd1);
        if (seen) begin
            fall_cyc = cyc;
            s[0] = uart_txd;
            for (int i = 1; i < 100; i++) begin
                @(negedge clk);
                s[i] = uart_txd;
            end
            for (int k = 0; k < 10; k++) begin
                check($sformatf("%s_bit%0d", tag, k), {22'd0, s[k*10 +: 10]},
                      {22'd0, {10{frame[k]}}});
            end
            $display("tb: echo %s byte 0x%02h captured, idle_before=%0d", tag, b, idle);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_led = 1'b0;
    endtask

    initial begin
        uart_rxd = 1'b1;
        rst      = 1'b1;
        exp_led  = 1'b0;

        // ---- Reset ----
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_led", {31'd0, led}, 32'd0);
        check("reset_txd", {31'd0, uart_txd}, 32'd1);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || led !== 1'b0) bad++;
        end
        check("reset_quiet", bad, 0);
        $display("tb: reset quiet window done");

        // ---- Single byte 0xA5 ----
        @(posedge clk);
        #1;
        fork
            send_byte(8'hA5, 1'b1);
            recv_echo(8'hA5, "single", idle0, fall0);
        join
        exp_led = ~exp_led;
        check($sformatf("single_latency_%0d_in_98_101", fall0 - last_start_cyc),
              {31'd0, ((fall0 - last_start_cyc) >= 98) && ((fall0 - last_start_cyc) <= 101)},
              32'd1);
        check("single_led", {31'd0, led}, {31'd0, exp_led});

        // ---- Back-to-back 0x00, 0xFF, 0x3C ----
        reset_pulse();
        @(posedge clk);
        #1;
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
                send_byte(8'h3C, 1'b1);
            end
            begin
                recv_echo(8'h00, "b2b0", idle0, fall0);
                recv_echo(8'hFF, "b2b1", idle1, fall1);
                recv_echo(8'h3C, "b2b2", idle2, fall2);
            end
        join
        exp_led = exp_led ^ 1'b1 ^ 1'b1 ^ 1'b1;
        check("b2b_gap1_le1", {31'd0, idle1 <= 1}, 32'd1);
        check("b2b_gap2_le1", {31'd0, idle2 <= 1}, 32'd1);
        check("b2b_led", {31'd0, led}, {31'd0, exp_led});

        // ---- Framing error 0x55 then good 0x12 ----
        @(posedge clk);
        #1;
        fork
            begin
                send_byte(8'h55, 1'b0);
                uart_rxd = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                send_byte(8'h12, 1'b1);
            end
            recv_echo(8'h12, "ferr", idle0, fall0);
        join
        exp_led = ~exp_led;
        check("ferr_led", {31'd0, led}, {31'd0, exp_led});

        // ---- Glitch: 3-cycle low pulse ----
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rxd = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || led !== exp_led) bad++;
        end
        check("glitch_quiet", bad, 0);
        check("glitch_led", {31'd0, led}, {31'd0, exp_led});
        $display("tb: glitch window done");

        // ---- Reset during echo data bits ----
        @(posedge clk);
        #1;
        found = 1'b0;
        fork
            send_byte(8'h81, 1'b1);
            for (int i = 0; i < TIMEOUT && !found; i++) begin
                @(negedge clk);
                if (uart_txd === 1'b0) found = 1'b1;
            end
        join
        check("rstmid_start_seen", {31'd0, found}, 32'd1);
        // 30 cycles in: bit 2 of 0x81 (a 0) is on the line.
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_txd_on_edge", {31'd0, uart_txd}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_led = 1'b0;
        check("rstmid_led", {31'd0, led}, 32'd0);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) bad++;
        end
        check("rstmid_quiet", bad, 0);
        $display("tb: mid-frame reset done");

        @(posedge clk);
        #1;
        fork
            send_byte(8'h6B, 1'b1);
            recv_echo(8'h6B, "after_rst", idle0, fall0);
        join
        exp_led = ~exp_led;
        check("after_rst_led", {31'd0, led}, {31'd0, exp_led});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
